// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: one-hot FSM states,
// data-width limits and the default phase-accumulator width.
package uart_pkg;

    localparam int ACC_W_DEF = 32;

    localparam logic [3:0] DATA_W_MIN = 4'd5;
    localparam logic [3:0] DATA_W_MAX = 4'd8;

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_START  = 5'b00010,
        S_DATA   = 5'b00100,
        S_PARITY = 5'b01000,
        S_STOP   = 5'b10000
    } state_t;

    // Out-of-range widths snap to the nearest legal frame size.
    function automatic logic [3:0] clamp_width(input logic [3:0] width);
        logic [3:0] result;
        result = width;
        if (width < DATA_W_MIN) begin
            result = DATA_W_MIN;
        end else if (width > DATA_W_MAX) begin
            result = DATA_W_MAX;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Phase-accumulator baud generator: tick is the carry-out of acc + fre_cnt,
// so the average tick rate is fre_cnt / 2^ACC_W per enabled clock.
module uart_baud_gen #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [ACC_W-1:0] fre_cnt,
    output logic             tick
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum  = {1'b0, acc} + {1'b0, fre_cnt};
    assign tick = enable & sum[ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5..8 data bits LSB first, optional parity and
// 1 or 2 stop bits, timed by the shared phase-accumulator baud scheme.
module uart_tx
    import uart_pkg::*;
#(
    parameter int   ACC_W      = ACC_W_DEF,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rstn,
    input  logic [ACC_W-1:0] i_fre_cnt,
    input  logic [3:0]       i_tx_data_bit,
    input  logic             i_parity_en,
    input  logic             i_parity_odd,
    input  logic             i_stop_2,
    input  logic [7:0]       i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic             o_tx_busy,
    output logic             o_tx_done,
    output logic             o_uart_tx
);

    state_t           state, state_nxt;
    logic [2:0]       idx, idx_nxt, idx_inc;
    logic             stop_cnt, stop_cnt_nxt;
    logic             line_nxt, done_nxt;
    logic             accept, tick, last_bit, parity_bit;
    logic [7:0]       data_q, data_mask;
    logic [3:0]       width_q;
    logic             par_en_q, par_odd_q, stop2_q;
    logic [ACC_W-1:0] fre_q;

    assign accept     = i_tx_valid & (state == S_IDLE);
    assign o_tx_ready = (state == S_IDLE);
    assign o_tx_busy  = (state != S_IDLE);

    uart_baud_gen #(
        .ACC_W(ACC_W)
    ) u_baud_gen (
        .clk    (i_sys_clk),
        .rst_n  (i_sys_rstn),
        .clear  (accept),
        .enable (state != S_IDLE),
        .fre_cnt(fre_q),
        .tick   (tick)
    );

    assign idx_inc    = idx + 3'd1;
    assign last_bit   = ({1'b0, idx} == (width_q - 4'd1));
    assign data_mask  = 8'hFF >> (4'd8 - width_q);
    assign parity_bit = (^(data_q & data_mask)) ^ par_odd_q;

    // Frame configuration is captured once so mid-frame input changes are ignored.
    always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
        if (!i_sys_rstn) begin
            data_q    <= '0;
            width_q   <= DATA_W_MAX;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            fre_q     <= '0;
        end else if (accept) begin
            data_q    <= i_tx_data;
            width_q   <= clamp_width(i_tx_data_bit);
            par_en_q  <= i_parity_en;
            par_odd_q <= i_parity_odd;
            stop2_q   <= i_stop_2;
            fre_q     <= i_fre_cnt;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
        if (!i_sys_rstn) begin
            state     <= S_IDLE;
            idx       <= '0;
            stop_cnt  <= 1'b0;
            o_uart_tx <= IDLE_LEVEL;
            o_tx_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            stop_cnt  <= stop_cnt_nxt;
            o_uart_tx <= line_nxt;
            o_tx_done <= done_nxt;
        end
    end

    // The line is computed for the upcoming state so it changes on the same
    // edge as the state, keeping every bit exactly one baud period long.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        stop_cnt_nxt = stop_cnt;
        line_nxt     = o_uart_tx;
        done_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                line_nxt = IDLE_LEVEL;
                if (accept) begin
                    state_nxt = S_START;
                    line_nxt  = ~IDLE_LEVEL;
                end
            end
            S_START: begin
                if (tick) begin
                    state_nxt = S_DATA;
                    idx_nxt   = 3'd0;
                    line_nxt  = data_q[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (last_bit) begin
                        if (par_en_q) begin
                            state_nxt = S_PARITY;
                            line_nxt  = parity_bit;
                        end else begin
                            state_nxt    = S_STOP;
                            stop_cnt_nxt = 1'b0;
                            line_nxt     = IDLE_LEVEL;
                        end
                    end else begin
                        idx_nxt  = idx_inc;
                        line_nxt = data_q[idx_inc];
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_nxt    = S_STOP;
                    stop_cnt_nxt = 1'b0;
                    line_nxt     = IDLE_LEVEL;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop2_q && !stop_cnt) begin
                        stop_cnt_nxt = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                line_nxt  = IDLE_LEVEL;
            end
        endcase
    end

endmodule
